// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer between program_counter, ROM
// and the decode stage. Drives PC load/increment, owns the instruction
// register and offers it to the decoder over a valid/ready handshake.
module fetch_controller #(
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic [15:0] HALT_OP    = 16'hC0FE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] INS,
  input  logic [15:0] PC_value,
  output logic [15:0] PC_in,
  output logic        PC_load,
  output logic        PC_CE,
  output logic [15:0] IR,
  output logic [15:0] IR_addr,
  output logic        IR_valid,
  input  logic        IR_ready,
  input  logic        branch_req,
  input  logic [15:0] branch_addr,
  input  logic        resume,
  output logic        halted
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir_nxt;
  logic [15:0] ir_addr_nxt;
  logic        ir_valid_nxt;
  logic        halted_nxt;
  logic        ins_is_halt;

  assign ins_is_halt = (INS == HALT_OP);

  // Next-state, registered-output next values and Mealy PC controls.
  always_comb begin
    state_nxt    = state;
    PC_load      = 1'b0;
    PC_CE        = 1'b0;
    PC_in        = START_ADDR;
    ir_nxt       = IR;
    ir_addr_nxt  = IR_addr;
    ir_valid_nxt = IR_valid;
    halted_nxt   = halted;

    case (state)
      INIT: begin
        PC_load      = 1'b1;
        ir_valid_nxt = 1'b0;
        state_nxt    = FETCH;
      end
      FETCH: begin
        ir_valid_nxt = 1'b0;
        if (ins_is_halt) begin
          // PC stays on the halt word so a debugger sees where we stopped.
          halted_nxt = 1'b1;
          state_nxt  = HALT;
        end else begin
          ir_nxt       = INS;
          ir_addr_nxt  = PC_value;
          ir_valid_nxt = 1'b1;
          PC_CE        = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (IR_ready) begin
          if (branch_req) begin
            // The word already on INS is the sequential one; drop it.
            PC_load      = 1'b1;
            PC_in        = branch_addr;
            ir_valid_nxt = 1'b0;
            state_nxt    = FETCH;
          end else if (ins_is_halt) begin
            ir_valid_nxt = 1'b0;
            halted_nxt   = 1'b1;
            state_nxt    = HALT;
          end else begin
            ir_nxt       = INS;
            ir_addr_nxt  = PC_value;
            ir_valid_nxt = 1'b1;
            PC_CE        = 1'b1;
          end
        end
      end
      HALT: begin
        ir_valid_nxt = 1'b0;
        if (resume) begin
          PC_load    = 1'b1;
          halted_nxt = 1'b0;
          state_nxt  = FETCH;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase

    // Reset overrides everything: park the PC on the start address.
    if (reset) begin
      PC_load = 1'b1;
      PC_CE   = 1'b0;
      PC_in   = START_ADDR;
    end
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      IR       <= 16'h0000;
      IR_addr  <= 16'h0000;
      IR_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      IR       <= ir_nxt;
      IR_addr  <= ir_addr_nxt;
      IR_valid <= ir_valid_nxt;
      halted   <= halted_nxt;
    end
  end

endmodule
